// File: rtl/uart_tx_fifo_if.sv
// Byte-write side and status/serial outputs of the buffered UART transmitter.
// The slave modport is the transmitter's view; master is the producer's.
interface uart_tx_fifo_if;
    logic [7:0] tx_data;
    logic       tx_tick;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic       fifo_empty;
    logic       overflow;

    modport slave (
        input  tx_data,
        input  tx_tick,
        output tx,
        output busy,
        output fifo_full,
        output fifo_empty,
        output overflow
    );

    modport master (
        output tx_data,
        output tx_tick,
        input  tx,
        input  busy,
        input  fifo_full,
        input  fifo_empty,
        input  overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: scancode bytes queue in a circular FIFO and
// are shifted out LSB first, back-to-back while the queue is non-empty.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int FIFO_ADDR_W  = 4
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_fifo_if.slave   bus
);
    localparam int                   DEPTH   = 2 ** FIFO_ADDR_W;
    localparam logic [FIFO_ADDR_W:0] CNT_ONE = (FIFO_ADDR_W + 1)'(1);
    localparam logic [FIFO_ADDR_W:0] CNT_FULL = (FIFO_ADDR_W + 1)'(DEPTH);
    localparam logic [15:0]          BIT_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [7:0]             mem_q [DEPTH];
    logic [FIFO_ADDR_W-1:0] wptr_q;
    logic [FIFO_ADDR_W-1:0] rptr_q;
    logic [FIFO_ADDR_W:0]   count_q;
    logic [FIFO_ADDR_W:0]   count_d;
    logic                   full_q;
    logic                   full_d;
    logic                   empty_q;
    logic                   empty_d;
    logic                   overflow_q;

    state_t                 state_q;
    logic [15:0]            cnt_q;
    logic [2:0]             bidx_q;
    logic [7:0]             sh_q;
    logic                   tx_q;
    logic                   busy_q;

    logic                   push;
    logic                   pop;
    logic                   bit_end;
    logic [7:0]             head;

    // The registered full flag alone decides acceptance, even if a pop frees a slot this cycle.
    assign push    = bus.tx_tick && !full_q;
    assign bit_end = (cnt_q == BIT_LAST);
    assign head    = mem_q[rptr_q];

    always_comb begin
        pop = 1'b0;
        if (!empty_q) begin
            case (state_q)
                IDLE:    pop = 1'b1;
                STOP:    pop = bit_end;
                default: pop = 1'b0;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= bus.tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + FIFO_ADDR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + FIFO_ADDR_W'(1);
            end
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            if (bus.tx_tick && full_q) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // tx and busy are assigned alongside each transition so they track the state entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bidx_q  <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        sh_q    <= head;
                        cnt_q   <= '0;
                        state_q <= START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        bidx_q  <= '0;
                        state_q <= DATA;
                        tx_q    <= sh_q[0];
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bidx_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bidx_q <= bidx_q + 3'd1;
                            sh_q   <= {1'b0, sh_q[7:1]};
                            tx_q   <= sh_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (pop) begin
                            sh_q    <= head;
                            state_q <= START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.fifo_full  = full_q;
    assign bus.fifo_empty = empty_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: a frame-timeline reference model predicts
// every output per cycle, and a UART decoder checks bytes against a scoreboard.
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 2 ** AW;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    uart_tx_fifo_if ifc ();

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_ADDR_W  (AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queued bytes, current frame start edge and byte.
    int         cyc = 0;
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    bit         m_busy = 1'b0;
    bit         m_ovf  = 1'b0;
    int         frame_start = 0;
    logic [7:0] frame_byte = 8'h00;
    int         rst_cnt = 0;

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", name, cyc, got, expv);
        end
    endtask

    initial begin
        forever begin
            int  sz;
            bit  do_push;
            bit  do_pop;
            int  off;
            logic exp_tx;
            @(posedge clk);
            cyc++;
            if (reset) begin
                mq.delete();
                exp_q.delete();
                m_busy = 1'b0;
                m_ovf  = 1'b0;
                rst_cnt++;
            end else begin
                sz      = mq.size();
                do_push = ifc.tx_tick && (sz < DEPTH);
                if (ifc.tx_tick && sz == DEPTH) m_ovf = 1'b1;
                do_pop = 1'b0;
                if (!m_busy) begin
                    if (sz > 0) do_pop = 1'b1;
                end else if (cyc == frame_start + 10 * CPB) begin
                    if (sz > 0) do_pop = 1'b1;
                    else m_busy = 1'b0;
                end
                if (do_pop) begin
                    frame_byte  = mq.pop_front();
                    frame_start = cyc;
                    m_busy      = 1'b1;
                end
                if (do_push) begin
                    mq.push_back(ifc.tx_data);
                    exp_q.push_back(ifc.tx_data);
                end
            end
            exp_tx = 1'b1;
            if (m_busy) begin
                off = cyc - frame_start;
                if (off < CPB) exp_tx = 1'b0;
                else if (off < 9 * CPB) exp_tx = frame_byte[(off / CPB) - 1];
            end
            #1;
            chk("tx", int'(ifc.tx), int'(exp_tx));
            chk("busy", int'(ifc.busy), int'(m_busy));
            chk("fifo_empty", int'(ifc.fifo_empty), int'(mq.size() == 0));
            chk("fifo_full", int'(ifc.fifo_full), int'(mq.size() == DEPTH));
            chk("overflow", int'(ifc.overflow), int'(m_ovf));
        end
    end

    task automatic wait_c(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Serial decoder: samples mid-bit and compares each frame with the scoreboard.
    initial begin
        forever begin
            int         r0;
            logic [7:0] got;
            logic       stop_bit;
            logic [7:0] expb;
            @(posedge clk);
            #2;
            if (ifc.tx === 1'b0 && !reset) begin
                r0 = rst_cnt;
                wait_c(CPB / 2);
                for (int i = 0; i < 8; i++) begin
                    wait_c(CPB);
                    got[i] = ifc.tx;
                end
                wait_c(CPB);
                stop_bit = ifc.tx;
                if (rst_cnt == r0) begin
                    $display("RX byte %02h stop %0d", got, stop_bit);
                    checks++;
                    if (stop_bit !== 1'b1) begin
                        errors++;
                        $display("FAIL stop_bit got %0d expected 1", stop_bit);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rx_byte got %02h expected none", got);
                    end else begin
                        expb = exp_q.pop_front();
                        if (got !== expb) begin
                            errors++;
                            $display("FAIL rx_byte got %02h expected %02h", got, expb);
                        end
                    end
                end
            end
        end
    end

    task automatic drive(input bit t, input logic [7:0] d);
        @(negedge clk);
        ifc.tx_tick = t;
        ifc.tx_data = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'($urandom));
    endtask

    task automatic drain(input string name, input int max);
        int n = 0;
        while ((m_busy || mq.size() != 0 || exp_q.size() != 0) && n < max) begin
            drive(1'b0, 8'($urandom));
            n++;
        end
        checks++;
        if (n >= max) begin
            errors++;
            $display("FAIL %s drain timeout busy %0d queued %0d pending %0d expected idle",
                     name, m_busy, mq.size(), exp_q.size());
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset       = 1'b1;
        ifc.tx_tick = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int g;
        ifc.tx_tick = 1'b0;
        ifc.tx_data = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(3);

        // single byte
        drive(1'b1, 8'h1C);
        drain("single", 100);
        idle(5);

        // break-code burst on consecutive ticks
        drive(1'b1, 8'hE0);
        drive(1'b1, 8'hF0);
        drive(1'b1, 8'h75);
        drain("burst", 300);
        idle(5);

        // fill past capacity
        for (int i = 1; i <= 6; i++) drive(1'b1, 8'(i));
        drain("overflow", 400);
        idle(5);
        do_reset(1);
        idle(3);

        // wrap-around at occupancy 1..3
        sent = 0;
        g    = 0;
        while (sent < 20 && g < 3000) begin
            if (mq.size() < 3 && $urandom_range(0, 1) == 1) begin
                drive(1'b1, 8'($urandom));
                sent++;
            end else begin
                drive(1'b0, 8'($urandom));
            end
            g++;
        end
        drain("wrap", 1000);
        idle(5);

        // reset during data bit 3 with two bytes queued
        drive(1'b1, 8'h11);
        drive(1'b1, 8'h22);
        drive(1'b1, 8'h33);
        g = 0;
        while (!(m_busy && (cyc + 1 - frame_start) == 4 * CPB + 1) && g < 200) begin
            drive(1'b0, 8'($urandom));
            g++;
        end
        chk("midframe_queued", mq.size(), 2);
        do_reset(1);
        idle(60);

        // tick lands on the edge that ends a stop bit
        drive(1'b1, 8'hA5);
        drive(1'b1, 8'h5A);
        g = 0;
        while ((cyc + 2) != frame_start + 10 * CPB && g < 200) begin
            drive(1'b0, 8'($urandom));
            g++;
        end
        drive(1'b1, 8'hC3);
        drive(1'b0, 8'h00);
        chk("pushpop_occupancy", mq.size(), 1);
        drain("pushpop", 400);
        idle(5);

        // random traffic, overflow allowed
        for (int i = 0; i < 300; i++) drive($urandom_range(0, 2) == 0, 8'($urandom));
        drain("random", 2000);
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
